// File: rtl/clock_recovery_pkg.sv
// clock_recovery_pkg: shared widths, clock-domain bundle, recovery FSM states and deviation helper
package clock_recovery_pkg;
   localparam int COUNTER_WIDTH = 16;
   localparam int RECOVERY_SYNC_STAGES_DEFAULT = 2;
   typedef logic [COUNTER_WIDTH-1:0] count_t;
   typedef struct packed {
      logic clk;
      logic clk_en;
      logic sync_rst;
   } clk_dom_t;
   typedef enum logic [1:0] {IDLE, ACQUIRE, TRACK, LOCKED} recovery_state_e;
   // One extra bit so the absolute difference never overflows
   function automatic logic [COUNTER_WIDTH:0] abs_diff(count_t a, count_t b);
      return (a > b) ? {1'b0, a} - {1'b0, b} : {1'b0, b} - {1'b0, a};
   endfunction
endpackage

// File: rtl/clock_recovery_if.sv
// clock_recovery_if: configuration, raw IO clock and recovery results between a host and clock_recovery
interface clock_recovery_if;
   import clock_recovery_pkg::*;
   logic   recovery_en_i;
   logic   io_clk_i;
   count_t expected_half_rate_minus_one_i;
   count_t tolerance_i;
   count_t timeout_minus_one_i;
   logic   posedge_sync_pulse_o;
   logic   negedge_sync_pulse_o;
   count_t sync_cycle_offset_o;
   logic   polarity_o;
   count_t measured_half_rate_minus_one_o;
   logic   measurement_valid_o;
   logic   locked_o;
   logic   clock_lost_o;
   modport master (
      output recovery_en_i, io_clk_i, expected_half_rate_minus_one_i, tolerance_i, timeout_minus_one_i,
      input  posedge_sync_pulse_o, negedge_sync_pulse_o, sync_cycle_offset_o, polarity_o,
             measured_half_rate_minus_one_o, measurement_valid_o, locked_o, clock_lost_o
   );
   modport slave (
      input  recovery_en_i, io_clk_i, expected_half_rate_minus_one_i, tolerance_i, timeout_minus_one_i,
      output posedge_sync_pulse_o, negedge_sync_pulse_o, sync_cycle_offset_o, polarity_o,
             measured_half_rate_minus_one_o, measurement_valid_o, locked_o, clock_lost_o
   );
endinterface

// File: rtl/clock_recovery_edge_synchronizer.sv
// edge_synchronizer: brings the async IO clock into the sys domain and flags its edges and direction
module edge_synchronizer #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic d_i,
   output logic edge_o,
   output logic dir_o
);
   logic [SYNC_STAGES-1:0] sync_q;
   logic                   hist_q;
   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q <= '0;
         hist_q <= 1'b0;
      end else if (en) begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
         hist_q <= sync_q[SYNC_STAGES-1];
      end
   end
   assign dir_o  = sync_q[SYNC_STAGES-1];
   assign edge_o = dir_o ^ hist_q;
endmodule

// File: rtl/clock_recovery.sv
// clock_recovery: measures the IO clock half period, locks once it matches the expected rate,
// then emits per-edge resync pulses for the local IO clock generator.
module clock_recovery
   import clock_recovery_pkg::*;
#(
   parameter int SYNC_STAGES = RECOVERY_SYNC_STAGES_DEFAULT,
   parameter int LOCK_COUNT  = 4
) (
   input clk_dom_t         sys_dom_i,
   clock_recovery_if.slave rec_if
);
   localparam int MW = $clog2(LOCK_COUNT + 1);
   if (SYNC_STAGES < 2 || LOCK_COUNT < 1) begin : g_bad_params
      $error("clock_recovery: SYNC_STAGES must be >= 2 and LOCK_COUNT >= 1");
   end
   logic            clk, rst, en;
   logic            edge_w, dir_w, in_tol, timeout, tracking, lock_hit;
   logic            pos_q, neg_q, valid_q, locked_q, lost_q;
   logic [MW-1:0]   match_q;
   count_t          cnt_q, meas_q;
   recovery_state_e state_q;
   assign clk = sys_dom_i.clk;
   assign rst = sys_dom_i.sync_rst;
   assign en  = sys_dom_i.clk_en;
   edge_synchronizer #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk    (clk),
      .rst    (rst),
      .en     (en),
      .d_i    (rec_if.io_clk_i),
      .edge_o (edge_w),
      .dir_o  (dir_w)
   );
   assign tracking = state_q inside {TRACK, LOCKED};
   assign in_tol   = abs_diff(cnt_q, rec_if.expected_half_rate_minus_one_i) <= {1'b0, rec_if.tolerance_i};
   assign timeout  = cnt_q == rec_if.timeout_minus_one_i;
   assign lock_hit = int'(match_q) + 1 >= LOCK_COUNT;
   // Priority inside an enabled cycle: disable, then edge, then timeout
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         match_q  <= '0;
         meas_q   <= '0;
         pos_q    <= 1'b0;
         neg_q    <= 1'b0;
         valid_q  <= 1'b0;
         locked_q <= 1'b0;
         lost_q   <= 1'b0;
      end else if (en) begin
         pos_q   <= 1'b0;
         neg_q   <= 1'b0;
         valid_q <= 1'b0;
         lost_q  <= 1'b0;
         cnt_q   <= tracking ? cnt_q + 1'b1 : '0;
         if (!rec_if.recovery_en_i) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            match_q  <= '0;
            locked_q <= 1'b0;
         end else if (state_q == IDLE) begin
            state_q <= ACQUIRE;
         end else if (state_q == ACQUIRE) begin
            if (edge_w) state_q <= TRACK;
         end else if (edge_w) begin
            cnt_q   <= '0;
            meas_q  <= cnt_q;
            valid_q <= 1'b1;
            if (!in_tol) begin
               state_q  <= TRACK;
               match_q  <= '0;
               locked_q <= 1'b0;
            end else if (state_q == LOCKED) begin
               pos_q <= dir_w;
               neg_q <= !dir_w;
            end else if (lock_hit) begin
               state_q  <= LOCKED;
               match_q  <= '0;
               locked_q <= 1'b1;
            end else begin
               match_q <= match_q + 1'b1;
            end
         end else if (timeout) begin
            state_q  <= ACQUIRE;
            cnt_q    <= '0;
            match_q  <= '0;
            locked_q <= 1'b0;
            lost_q   <= 1'b1;
         end
      end
   end
   assign rec_if.posedge_sync_pulse_o           = pos_q;
   assign rec_if.negedge_sync_pulse_o           = neg_q;
   assign rec_if.sync_cycle_offset_o            = count_t'(SYNC_STAGES + 1);
   assign rec_if.polarity_o                     = dir_w;
   assign rec_if.measured_half_rate_minus_one_o = meas_q;
   assign rec_if.measurement_valid_o            = valid_q;
   assign rec_if.locked_o                       = locked_q;
   assign rec_if.clock_lost_o                   = lost_q;
endmodule

// File: tb/tb_clock_recovery.sv
// tb_clock_recovery: directed lock/drift/loss/disable/reset scenarios plus randomized traffic,
// every cycle compared against a delayed-level behavioural model of the receiver.
module tb_clock_recovery;
   import clock_recovery_pkg::*;
   localparam int S = 2, LC = 4;
   localparam int M_IDLE = 0, M_ACQ = 1, M_TRACK = 2, M_LOCK = 3;
   logic clk = 1'b0, ce = 1'b1, rst = 1'b1;
   clk_dom_t sys_dom;
   clock_recovery_if rif();
   assign sys_dom = {clk, ce, rst};
   clock_recovery #(.SYNC_STAGES(S), .LOCK_COUNT(LC)) dut (.sys_dom_i(sys_dom), .rec_if(rif));
   always #5 clk = ~clk;
   int n_chk = 0, n_pass = 0;
   int cyc = 0, tog_cyc = 0, n_pulse = 0, n_lost = 0, lost_cyc = 0;
   bit lat_chk = 0, rnd_ce = 0, started = 0;
   int m_mode, m_count, m_good, m_meas;
   bit e_pos, e_neg, e_valid, e_lost, e_pol;
   bit h[$];
   function automatic void chk(string name, int act, int exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
   endfunction
   // The receiver sees the IO level delayed by S enabled samples; an edge is a change in that view
   function automatic void model_step(bit r, bit c, bit en, bit io, int exp, int tol, int tmo);
      bit lvl, prev, seen;
      int dev;
      if (r) begin
         m_mode = M_IDLE; m_count = 0; m_good = 0; m_meas = 0;
         {e_pos, e_neg, e_valid, e_lost, e_pol} = 5'b0;
         h = {};
         repeat (S + 1) h.push_back(1'b0);
         return;
      end
      if (!c) return;
      lvl = h[S-1];
      prev = h[S];
      seen = lvl != prev;
      h.push_front(io);
      void'(h.pop_back());
      e_pol = h[S-1];
      {e_pos, e_neg, e_valid, e_lost} = 4'b0;
      if (!en) begin
         m_mode = M_IDLE; m_count = 0; m_good = 0;
      end else if (m_mode == M_IDLE) m_mode = M_ACQ;
      else if (m_mode == M_ACQ) begin
         if (seen) m_mode = M_TRACK;
      end else if (seen) begin
         m_meas = m_count;
         m_count = 0;
         e_valid = 1;
         dev = m_meas - exp;
         if (dev < 0) dev = -dev;
         if (dev > tol) begin
            m_mode = M_TRACK; m_good = 0;
         end else if (m_mode == M_LOCK) begin
            e_pos = lvl; e_neg = !lvl;
         end else begin
            m_good++;
            if (m_good == LC) begin m_mode = M_LOCK; m_good = 0; end
         end
      end else if (m_count == tmo) begin
         e_lost = 1; m_mode = M_ACQ; m_good = 0; m_count = 0;
      end else m_count++;
   endfunction
   initial begin
      forever begin
         @(posedge clk);
         cyc++;
         if (rst) started = 1;
         if (started)
            model_step(rst, ce, rif.recovery_en_i, rif.io_clk_i, int'(rif.expected_half_rate_minus_one_i),
                       int'(rif.tolerance_i), int'(rif.timeout_minus_one_i));
         #2;
         if (started) begin
            chk("posedge_pulse", rif.posedge_sync_pulse_o, e_pos);
            chk("negedge_pulse", rif.negedge_sync_pulse_o, e_neg);
            chk("valid", rif.measurement_valid_o, e_valid);
            chk("clock_lost", rif.clock_lost_o, e_lost);
            chk("polarity", rif.polarity_o, e_pol);
            chk("locked", rif.locked_o, m_mode == M_LOCK);
            chk("measured", int'(rif.measured_half_rate_minus_one_o), m_meas);
            chk("offset", int'(rif.sync_cycle_offset_o), S + 1);
            if (rif.posedge_sync_pulse_o || rif.negedge_sync_pulse_o) n_pulse++;
            if (lat_chk && rif.posedge_sync_pulse_o) chk("pos_latency", cyc - tog_cyc, 3);
            if (lat_chk && rif.negedge_sync_pulse_o) chk("neg_latency", cyc - tog_cyc, 3);
            if (rif.clock_lost_o) begin n_lost++; lost_cyc = cyc; end
         end
      end
   end
   task automatic tick(int n);
      repeat (n) begin
         @(posedge clk);
         #1;
         ce = rnd_ce ? ($urandom_range(0, 9) != 0) : 1'b1;
      end
   endtask
   task automatic half(int n);
      rif.io_clk_i = ~rif.io_clk_i;
      tog_cyc = cyc;
      tick(n);
   endtask
   task automatic chk_reset_outputs();
      chk("rst_locked", rif.locked_o, 0);
      chk("rst_measured", int'(rif.measured_half_rate_minus_one_o), 0);
      chk("rst_strobes", int'({rif.posedge_sync_pulse_o, rif.negedge_sync_pulse_o, rif.measurement_valid_o,
                               rif.clock_lost_o, rif.polarity_o}), 0);
      chk("rst_offset", int'(rif.sync_cycle_offset_o), 3);
   endtask
   task automatic run_random(int exp, int tol, int tmo, int len);
      int stop;
      rif.expected_half_rate_minus_one_i = count_t'(exp);
      rif.tolerance_i = count_t'(tol);
      rif.timeout_minus_one_i = count_t'(tmo);
      stop = cyc + len;
      while (cyc < stop) begin
         int r;
         r = $urandom_range(0, 99);
         if (r < 3) begin
            rst = 1; tick($urandom_range(1, 3)); rst = 0;
         end else if (r < 7) begin
            rif.recovery_en_i = 0; tick($urandom_range(1, 5)); rif.recovery_en_i = 1;
         end else if (r < 11) half($urandom_range(tmo, tmo + 14));
         else if (r < 15) half($urandom_range(2, 4));
         else half($urandom_range(exp - 1, exp + 3));
      end
   endtask
   initial begin
      int p0;
      rif.recovery_en_i = 0;
      rif.io_clk_i = 0;
      rif.expected_half_rate_minus_one_i = 16'd9;
      rif.tolerance_i = 16'd1;
      rif.timeout_minus_one_i = 16'd31;
      tick(3);
      chk_reset_outputs();
      rst = 0;
      rif.recovery_en_i = 1;
      lat_chk = 1;
      tick(2);
      for (int i = 0; i < 12; i++) half(10);
      chk("lock_locked", rif.locked_o, 1);
      chk("lock_measured", int'(rif.measured_half_rate_minus_one_o), 9);
      p0 = n_pulse;
      for (int i = 0; i < 6; i++) half(11);
      chk("drift_measured", int'(rif.measured_half_rate_minus_one_o), 10);
      chk("drift_locked", rif.locked_o, 1);
      chk("drift_pulses", n_pulse - p0, 6);
      half(13);
      half(10);
      chk("bad_measured", int'(rif.measured_half_rate_minus_one_o), 12);
      chk("bad_unlocked", rif.locked_o, 0);
      for (int i = 0; i < 3; i++) half(10);
      chk("relock_3_edges", rif.locked_o, 0);
      half(10);
      chk("relock_4_edges", rif.locked_o, 1);
      n_lost = 0;
      tick(45);
      chk("loss_count", n_lost, 1);
      chk("loss_delay", lost_cyc - tog_cyc, 35);
      chk("loss_unlocked", rif.locked_o, 0);
      for (int i = 0; i < 4; i++) half(10);
      chk("reacq_4_edges", rif.locked_o, 0);
      half(10);
      chk("reacq_5_edges", rif.locked_o, 1);
      rif.recovery_en_i = 0;
      p0 = n_pulse;
      n_lost = 0;
      tick(1);
      chk("disable_unlocked", rif.locked_o, 0);
      for (int i = 0; i < 3; i++) half(10);
      chk("disable_pulses", n_pulse - p0, 0);
      chk("disable_lost", n_lost, 0);
      rif.recovery_en_i = 1;
      tick(2);
      for (int i = 0; i < 3; i++) half(10);
      rst = 1;
      rif.recovery_en_i = 0;
      rif.io_clk_i = 0;
      tick(3);
      chk_reset_outputs();
      rst = 0;
      rif.recovery_en_i = 1;
      tick(2);
      for (int i = 0; i < 4; i++) half(10);
      chk("rst_relock_4_edges", rif.locked_o, 0);
      half(10);
      chk("rst_relock_5_edges", rif.locked_o, 1);
      lat_chk = 0;
      rnd_ce = 1;
      run_random(9, 1, 31, 3000);
      run_random(5, 0, 15, 3000);
      rnd_ce = 0;
      ce = 1;
      tick(2);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
